tree_exec_ctrl: RTL and testbench
=================================

TREE_EXEC_CTRL -- requirements
Module: tree_exec_ctrl

Interface
REQ-001 Parameters:
- N_TREE, 2, number of ALU trees in the processing block.
- N_ALU_PER_TREE, 7, ALUs per tree in heap order (index 0 = top).
- TREE_DEPTH, 3, levels per tree; N_ALU_PER_TREE = 2**TREE_DEPTH-1.
- MODE_W, 2, per-ALU mode width.
- TAG_W, 8, instruction tag width.
REQ-002 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instr_vld  in  1  instruction offered.
- instr_rdy  out  1  instruction accepted this cycle when high with instr_vld.
- instr_mode  in  N_TREE*N_ALU_PER_TREE*MODE_W  mode vector; tree t, ALU j at field t*N_ALU_PER_TREE+j.
- instr_tag  in  TAG_W  tag returned with the result.
- instr_last  in  1  marks the final instruction of a program.
- pb_en  out  1  global enable to the processing block.
- pb_alu_mode  out  same width as instr_mode  per-ALU mode, same field layout.
- res_vld  out  1  top-ALU outputs hold the result of res_tag.
- res_tag  out  TAG_W  tag of the presented result.
- res_rdy  in  1  consumer accepts the result.
- done  out  1  one-cycle pulse when a program is fully drained.
- issue_cnt  out  16  instructions accepted since reset.

Function
REQ-003 Mode encoding: SUM=0, PROD=1, PASS_0=2, PASS_1=3. PASS_1 is the hold/bubble code.
REQ-004 Accept on instr_vld && instr_rdy; instr_rdy = (state != DRAIN) && !stall.
REQ-005 stall = res_vld && !res_rdy; pb_en = !stall (combinational).
REQ-006 Wavefront skew: ALU j at heap depth d (2**d-1 <= j <= 2**(d+1)-2) is tree level lvl = TREE_DEPTH-d.
REQ-007 Skew delay: its field on pb_alu_mode equals that field of the instruction accepted lvl-1 enabled cycles earlier.
REQ-008 Level-1 fields are driven combinationally from instr_mode in the accept cycle.
REQ-009 Any level-lvl field whose corresponding delay slot holds no instruction (bubble) is driven PASS_1. This includes level-1 fields in a cycle with no accept.
REQ-010 All delay lines, valid bits and tags advance only in cycles with pb_en=1; during stall every register holds.
REQ-011 Latency: an instruction accepted in enabled cycle t raises res_vld in the TREE_DEPTH-th enabled cycle after t, with res_tag = its instr_tag.
REQ-012 res_vld stays high with res_tag stable until res_rdy=1.
REQ-013 Back-to-back accepts yield back-to-back results, throughput 1 per enabled cycle.
REQ-014 The FSM has three states: IDLE, RUN, DRAIN.
- IDLE->RUN on accept with instr_last=0.
- IDLE or RUN -> DRAIN on accept with instr_last=1.
- RUN->IDLE never; RUN persists between bursts.
- DRAIN->IDLE when no valid bit is set in the pipeline and no res_vld is pending; done=1 in that transition cycle only.
REQ-015 Accept with instr_last=1 and an otherwise empty pipeline: done fires exactly one cycle after that result's res_vld&&res_rdy handshake.
REQ-016 issue_cnt increments by 1 per accept and wraps from 16'hFFFF to 0.
REQ-017 instr_mode, instr_tag and instr_last are ignored when not accepted.

Reset
REQ-018 rst=0 asynchronously sets: state=IDLE, all valid bits=0, res_vld=0, res_tag=0, done=0, issue_cnt=0, all pb_alu_mode fields=PASS_1, pb_en=1.
REQ-019 Reset mid-operation discards all in-flight instructions; no res_vld or done follows for them.
REQ-020 The first accept is possible in the first cycle after rst deasserts.

Verification
REQ-021 Single instruction: tag 0x11, all SUM, last=0, res_rdy=1 -> level-2 fields SUM one cycle after accept, top field SUM two cycles after accept; res_vld with tag 0x11 exactly 3 cycles after accept; other fields PASS_1.
REQ-022 Burst: tags 1..5 on consecutive cycles, res_rdy=1 -> res_vld high for 5 consecutive cycles with tags 1..5; issue_cnt=5.
REQ-023 Backpressure: burst of tags 1..4, res_rdy=0 for 3 cycles when tag 1 is presented -> pb_en=0 and instr_rdy=0 for those 3 cycles, pb_alu_mode frozen, then tags 1..4 delivered in order with none lost or duplicated.
REQ-024 Drain: tags 7 and 8 with 8 marked last -> instr_rdy=0 from the cycle after tag 8 is accepted; done pulses once, one cycle after the tag-8 handshake; state returns to IDLE and instr_rdy=1.
REQ-025 Reset mid-flight: rst=0 one cycle after accepting tag 0x22 -> after release, res_vld stays 0 for 5 cycles, issue_cnt=0, all fields PASS_1.
REQ-026 Wrap: preload via 65536 accepts -> issue_cnt reads 0.

Source files
------------

// File: rtl/tree_exec_ctrl.sv
// rtl/tree_exec_ctrl.sv - issue/drain controller driving skewed per-ALU modes into an ALU-tree processing block
module tree_exec_ctrl #(
    parameter int N_TREE         = 2,
    parameter int N_ALU_PER_TREE = 7,
    parameter int TREE_DEPTH     = 3,
    parameter int MODE_W         = 2,
    parameter int TAG_W          = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     instr_vld,
    output logic                                     instr_rdy,
    input  logic [N_TREE*N_ALU_PER_TREE*MODE_W-1:0]  instr_mode,
    input  logic [TAG_W-1:0]                         instr_tag,
    input  logic                                     instr_last,
    output logic                                     pb_en,
    output logic [N_TREE*N_ALU_PER_TREE*MODE_W-1:0]  pb_alu_mode,
    output logic                                     res_vld,
    output logic [TAG_W-1:0]                         res_tag,
    input  logic                                     res_rdy,
    output logic                                     done,
    output logic [15:0]                              issue_cnt
);

    localparam int NF = N_TREE * N_ALU_PER_TREE;
    localparam int NS = TREE_DEPTH - 1;
    localparam logic [MODE_W-1:0] PASS_1 = MODE_W'(3);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               stall;
    logic               accept;
    logic               any_vld;
    logic [NS-1:0]      vld;
    logic [TAG_W-1:0]   tag [NS];

    function automatic int heap_depth(input int j);
        int d;
        d = 0;
        for (int k = 1; k < 31; k++) begin
            if (j >= (1 << k) - 1) d = k;
        end
        return d;
    endfunction

    assign stall     = res_vld && !res_rdy;
    assign pb_en     = !stall;
    assign instr_rdy = (state != DRAIN) && !stall;
    assign accept    = instr_vld && instr_rdy;
    assign any_vld   = |vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = instr_last ? DRAIN : RUN;
            end
            RUN: begin
                if (accept && instr_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!any_vld && !res_vld) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slot k of vld/tag holds the instruction accepted k+1 enabled cycles ago.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld       <= '0;
            for (int i = 0; i < NS; i++) tag[i] <= '0;
            res_vld   <= 1'b0;
            res_tag   <= '0;
            issue_cnt <= 16'd0;
        end else begin
            if (accept) issue_cnt <= issue_cnt + 16'd1;
            if (pb_en) begin
                vld[0] <= accept;
                if (accept) tag[0] <= instr_tag;
                for (int i = 1; i < NS; i++) begin
                    vld[i] <= vld[i-1];
                    tag[i] <= tag[i-1];
                end
                res_vld <= vld[NS-1];
                if (vld[NS-1]) res_tag <= tag[NS-1];
            end
        end
    end

    genvar f;
    generate
        for (f = 0; f < NF; f++) begin : g_field
            localparam int J   = f % N_ALU_PER_TREE;
            localparam int LVL = TREE_DEPTH - heap_depth(J);

            logic [MODE_W-1:0] in_field;
            assign in_field = instr_mode[f*MODE_W +: MODE_W];

            if (LVL == 1) begin : g_leaf
                assign pb_alu_mode[f*MODE_W +: MODE_W] = accept ? in_field : PASS_1;
            end else begin : g_dly
                // Upper levels see the same instruction later so the wavefront meets at the top ALU.
                logic [MODE_W-1:0] dly [LVL-1];

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        for (int i = 0; i < LVL-1; i++) dly[i] <= PASS_1;
                    end else if (pb_en) begin
                        dly[0] <= in_field;
                        for (int i = 1; i < LVL-1; i++) dly[i] <= dly[i-1];
                    end
                end

                assign pb_alu_mode[f*MODE_W +: MODE_W] = vld[LVL-2] ? dly[LVL-2] : PASS_1;
            end
        end
    endgenerate

endmodule

// File: tb/tb_tree_exec_ctrl.sv
// tb/tb_tree_exec_ctrl.sv - vector table plus scoreboard bench for tree_exec_ctrl
module tb_tree_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_vld = 1'b0;
    logic        instr_rdy;
    logic [27:0] instr_mode = '1;
    logic [7:0]  instr_tag = 8'h00;
    logic        instr_last = 1'b0;
    logic        pb_en;
    logic [27:0] pb_alu_mode;
    logic        res_vld;
    logic [7:0]  res_tag;
    logic        res_rdy = 1'b1;
    logic        done;
    logic [15:0] issue_cnt;

    int          checks = 0;
    int          failures = 0;
    int          exp_cnt = 0;
    logic [7:0]  sb [$];

    typedef struct {
        bit       vld;
        bit [7:0] tag;
        bit [1:0] code;
        bit       last;
        bit       rdy;
        bit       e_irdy;
        bit       e_pben;
        bit       e_rvld;
        bit [7:0] e_rtag;
        bit [1:0] e1;
        bit [1:0] e2;
        bit [1:0] e3;
    } vec_t;

    vec_t tbl [$];

    tree_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_vld   (instr_vld),
        .instr_rdy   (instr_rdy),
        .instr_mode  (instr_mode),
        .instr_tag   (instr_tag),
        .instr_last  (instr_last),
        .pb_en       (pb_en),
        .pb_alu_mode (pb_alu_mode),
        .res_vld     (res_vld),
        .res_tag     (res_tag),
        .res_rdy     (res_rdy),
        .done        (done),
        .issue_cnt   (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] fill(input logic [1:0] c);
        logic [27:0] r;
        for (int i = 0; i < 14; i++) r[i*2 +: 2] = c;
        return r;
    endfunction

    // Leaf ALUs 3..6 are level 1, ALUs 1..2 level 2, ALU 0 (top) level 3.
    function automatic logic [27:0] lvlvec(input logic [1:0] c1, input logic [1:0] c2, input logic [1:0] c3);
        int lv [7] = '{3, 2, 2, 1, 1, 1, 1};
        logic [27:0] r;
        for (int t = 0; t < 2; t++) begin
            for (int j = 0; j < 7; j++) begin
                case (lv[j])
                    1:       r[(t*7+j)*2 +: 2] = c1;
                    2:       r[(t*7+j)*2 +: 2] = c2;
                    default: r[(t*7+j)*2 +: 2] = c3;
                endcase
            end
        end
        return r;
    endfunction

    function automatic vec_t v(input bit vld, input bit [7:0] tag, input bit [1:0] code, input bit last,
                               input bit rdy, input bit e_irdy, input bit e_pben, input bit e_rvld,
                               input bit [7:0] e_rtag, input bit [1:0] e1, input bit [1:0] e2, input bit [1:0] e3);
        vec_t r;
        r.vld = vld; r.tag = tag; r.code = code; r.last = last; r.rdy = rdy;
        r.e_irdy = e_irdy; r.e_pben = e_pben; r.e_rvld = e_rvld; r.e_rtag = e_rtag;
        r.e1 = e1; r.e2 = e2; r.e3 = e3;
        return r;
    endfunction

    task automatic set_in(input bit vld, input bit [7:0] tag, input bit [1:0] code, input bit last, input bit rdy);
        instr_vld  = vld;
        instr_tag  = tag;
        instr_mode = fill(code);
        instr_last = last;
        res_rdy    = rdy;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: tags queued at accept, popped at result handshake; issue count tracked alongside.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            exp_cnt = 0;
        end else begin
            chk("issue_cnt", {16'd0, issue_cnt}, {16'd0, 16'(exp_cnt)});
            if (res_vld && res_rdy) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_res", {31'd0, res_vld}, 32'd0);
                end else begin
                    chk("sb_res_tag", {24'd0, res_tag}, {24'd0, sb.pop_front()});
                end
            end
            if (instr_vld && instr_rdy) begin
                sb.push_back(instr_tag);
                exp_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // single instruction, all SUM
        tbl.push_back(v(1, 8'h11, 0, 0, 1, 1, 1, 0, 8'h00, 0, 3, 3));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 3, 0, 3));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 3, 3, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 1, 8'h11, 3, 3, 3));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 3, 3, 3));
        // burst of five
        tbl.push_back(v(1, 8'h01, 1, 0, 1, 1, 1, 0, 8'h00, 1, 3, 3));
        tbl.push_back(v(1, 8'h02, 2, 0, 1, 1, 1, 0, 8'h00, 2, 1, 3));
        tbl.push_back(v(1, 8'h03, 0, 0, 1, 1, 1, 0, 8'h00, 0, 2, 1));
        tbl.push_back(v(1, 8'h04, 1, 0, 1, 1, 1, 1, 8'h01, 1, 0, 2));
        tbl.push_back(v(1, 8'h05, 0, 0, 1, 1, 1, 1, 8'h02, 0, 1, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 1, 8'h03, 3, 0, 1));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 1, 8'h04, 3, 3, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 1, 8'h05, 3, 3, 3));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 3, 3, 3));
        // burst of four with three stall cycles at the first result
        tbl.push_back(v(1, 8'h01, 1, 0, 1, 1, 1, 0, 8'h00, 1, 3, 3));
        tbl.push_back(v(1, 8'h02, 2, 0, 1, 1, 1, 0, 8'h00, 2, 1, 3));
        tbl.push_back(v(1, 8'h03, 0, 0, 1, 1, 1, 0, 8'h00, 0, 2, 1));
        tbl.push_back(v(1, 8'h04, 1, 0, 0, 0, 0, 1, 8'h01, 3, 0, 2));
        tbl.push_back(v(1, 8'h04, 1, 0, 0, 0, 0, 1, 8'h01, 3, 0, 2));
        tbl.push_back(v(1, 8'h04, 1, 0, 0, 0, 0, 1, 8'h01, 3, 0, 2));
        tbl.push_back(v(1, 8'h04, 1, 0, 1, 1, 1, 1, 8'h01, 1, 0, 2));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 1, 8'h02, 3, 1, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 1, 8'h03, 3, 3, 1));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 1, 8'h04, 3, 3, 3));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 3, 3, 3));

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_res_vld", {31'd0, res_vld}, 32'd0);
        chk("rst_res_tag", {24'd0, res_tag}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pb_en", {31'd0, pb_en}, 32'd1);
        chk("rst_issue_cnt", {16'd0, issue_cnt}, 32'd0);
        chk("rst_modes", {4'd0, pb_alu_mode}, {4'd0, fill(2'd3)});
        chk("rst_instr_rdy", {31'd0, instr_rdy}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (tbl[i]) begin
            set_in(tbl[i].vld, tbl[i].tag, tbl[i].code, tbl[i].last, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("v%0d_instr_rdy", i), {31'd0, instr_rdy}, {31'd0, tbl[i].e_irdy});
            chk($sformatf("v%0d_pb_en", i), {31'd0, pb_en}, {31'd0, tbl[i].e_pben});
            chk($sformatf("v%0d_res_vld", i), {31'd0, res_vld}, {31'd0, tbl[i].e_rvld});
            if (tbl[i].e_rvld)
                chk($sformatf("v%0d_res_tag", i), {24'd0, res_tag}, {24'd0, tbl[i].e_rtag});
            chk($sformatf("v%0d_modes", i), {4'd0, pb_alu_mode},
                {4'd0, lvlvec(tbl[i].e1, tbl[i].e2, tbl[i].e3)});
            chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd0);
            next_cyc();
        end

        // drain: tag 7 then tag 8 marked last
        set_in(1, 8'h07, 0, 0, 1);
        @(negedge clk); chk("dr_rdy_t7", {31'd0, instr_rdy}, 32'd1);
        next_cyc();
        set_in(1, 8'h08, 1, 1, 1);
        @(negedge clk); chk("dr_rdy_t8", {31'd0, instr_rdy}, 32'd1);
        next_cyc();
        set_in(1, 8'h09, 2, 0, 1);
        @(negedge clk); chk("dr_rdy_blocked0", {31'd0, instr_rdy}, 32'd0);
        chk("dr_done_early0", {31'd0, done}, 32'd0);
        next_cyc();
        @(negedge clk); chk("dr_rdy_blocked1", {31'd0, instr_rdy}, 32'd0);
        chk("dr_res_t7", {23'd0, res_vld, res_tag}, {23'd0, 1'b1, 8'h07});
        next_cyc();
        @(negedge clk); chk("dr_res_t8", {23'd0, res_vld, res_tag}, {23'd0, 1'b1, 8'h08});
        chk("dr_done_early1", {31'd0, done}, 32'd0);
        next_cyc();
        set_in(0, 8'h00, 0, 0, 1);
        @(negedge clk); chk("dr_done_pulse", {31'd0, done}, 32'd1);
        chk("dr_rdy_in_drain", {31'd0, instr_rdy}, 32'd0);
        next_cyc();
        @(negedge clk); chk("dr_done_once", {31'd0, done}, 32'd0);
        chk("dr_rdy_idle", {31'd0, instr_rdy}, 32'd1);
        next_cyc();

        // reset one cycle after accepting tag 0x22
        set_in(1, 8'h22, 0, 0, 1);
        @(negedge clk);
        next_cyc();
        set_in(0, 8'h00, 0, 0, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_in_rst_modes", {4'd0, pb_alu_mode}, {4'd0, fill(2'd3)});
        chk("mr_in_rst_res_vld", {31'd0, res_vld}, 32'd0);
        next_cyc();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("mr%0d_res_vld", k), {31'd0, res_vld}, 32'd0);
            chk($sformatf("mr%0d_issue_cnt", k), {16'd0, issue_cnt}, 32'd0);
            chk($sformatf("mr%0d_modes", k), {4'd0, pb_alu_mode}, {4'd0, fill(2'd3)});
            chk($sformatf("mr%0d_done", k), {31'd0, done}, 32'd0);
            next_cyc();
        end

        // 65536 accepts wrap the issue counter
        for (int k = 0; k < 65536; k++) begin
            set_in(1, 8'(k), 2'(k % 3), 0, 1);
            next_cyc();
        end
        set_in(0, 8'h00, 0, 0, 1);
        @(negedge clk);
        chk("wrap_issue_cnt", {16'd0, issue_cnt}, 32'd0);
        repeat (4) next_cyc();
        @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
